// File: rtl/cnn_pkg.sv
// Shared constants for the conv -> max-pool datapath.
package cnn_pkg;
  localparam int CONV_COLS  = 24;
  localparam int CONV_PIX_W = 15;
  localparam int CONV_ROWS  = 24;
  localparam int POOL_OUT_W = 4;
  localparam int ROW_W      = CONV_COLS * CONV_PIX_W;
  localparam int PAIR_W     = 2 * ROW_W;
endpackage

// File: rtl/row_pair_buffer.sv
// Two-row staging buffer: even/odd row registers plus a pair_full flag that
// holds off further rows until the pair has been issued to the pooling stage.
module row_pair_buffer
  import cnn_pkg::*;
#(
  parameter int RW = ROW_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          accept,
  input  logic          odd_row,
  input  logic          issue,
  input  logic [RW-1:0] row_in,
  output logic [RW-1:0] even_buf,
  output logic [RW-1:0] odd_buf,
  output logic          pair_full
);

  // accept and issue are mutually exclusive: accept needs !pair_full, issue needs pair_full
  always_ff @(posedge clk) begin
    if (reset) begin
      pair_full <= 1'b0;
    end else if (accept && odd_row) begin
      pair_full <= 1'b1;
    end else if (issue) begin
      pair_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      even_buf <= '0;
      odd_buf  <= '0;
    end else if (accept) begin
      if (odd_row) odd_buf  <= row_in;
      else         even_buf <= row_in;
    end
  end

endmodule

// File: rtl/conv_row_pair_packer.sv
// Packs conv rows into {even,odd} pool words, throttled by the pooling stage's
// busy/end handshake, and counts pairs to flag the end of each frame.
module conv_row_pair_packer
  import cnn_pkg::*;
#(
  parameter int COLS  = CONV_COLS,
  parameter int PIX_W = CONV_PIX_W,
  parameter int ROWS  = CONV_ROWS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    row_valid,
  output logic                    row_ready,
  input  logic [COLS*PIX_W-1:0]   row_in,
  output logic                    pool_start,
  output logic [2*COLS*PIX_W-1:0] pool_in,
  input  logic                    pool_end,
  output logic                    frame_done
);

  localparam int RW    = COLS * PIX_W;
  localparam int PAIRS = ROWS / 2;
  localparam int CNT_W = $clog2(ROWS);
  localparam int PD_W  = $clog2(PAIRS) + 1;

  logic [CNT_W-1:0] row_cnt;
  logic [PD_W-1:0]  pairs_done;
  logic             busy;
  logic             frame_rows_taken;
  logic             pair_full;
  logic [RW-1:0]    even_buf;
  logic [RW-1:0]    odd_buf;

  logic accept, issue, complete, last_row, last_pair;

  assign row_ready = !reset && !pair_full && !frame_rows_taken;
  assign accept    = row_valid && row_ready;
  // issue looks at registered busy, so a pool_end never allows a same-edge reissue
  assign issue     = pair_full && !busy;
  assign complete  = pool_end && busy;
  assign last_row  = accept && (row_cnt == CNT_W'(ROWS - 1));
  assign last_pair = complete && (pairs_done == PD_W'(PAIRS - 1));

  row_pair_buffer #(.RW(RW)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .accept    (accept),
    .odd_row   (row_cnt[0]),
    .issue     (issue),
    .row_in    (row_in),
    .even_buf  (even_buf),
    .odd_buf   (odd_buf),
    .pair_full (pair_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt          <= '0;
      pairs_done       <= '0;
      busy             <= 1'b0;
      frame_rows_taken <= 1'b0;
      pool_start       <= 1'b0;
      pool_in          <= '0;
      frame_done       <= 1'b0;
    end else begin
      pool_start <= issue;
      frame_done <= last_pair;

      if (issue) pool_in <= {even_buf, odd_buf};

      if (issue)         busy <= 1'b1;
      else if (complete) busy <= 1'b0;

      // last_pair cannot coincide with accept: frame_rows_taken blocks rows until it fires
      if (last_pair)   row_cnt <= '0;
      else if (accept) row_cnt <= last_row ? '0 : row_cnt + CNT_W'(1);

      if (last_pair)     frame_rows_taken <= 1'b0;
      else if (last_row) frame_rows_taken <= 1'b1;

      if (last_pair)     pairs_done <= '0;
      else if (complete) pairs_done <= pairs_done + PD_W'(1);
    end
  end

endmodule

// File: tb/tb_conv_row_pair_packer.sv
// Bench for conv_row_pair_packer: cycle table for handshake corners, scoreboard
// on pool_in, and a full-frame run with an auto-responding pooling stage.
module tb_conv_row_pair_packer;
  import cnn_pkg::*;

  localparam int RW = ROW_W;
  localparam int PW = PAIR_W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          row_valid = 1'b0;
  logic [RW-1:0] row_in = '0;
  logic          man_end = 1'b0;
  logic          auto_end = 1'b0;
  logic          pool_end;
  logic          row_ready, pool_start, frame_done;
  logic [PW-1:0] pool_in;

  assign pool_end = man_end | auto_end;

  conv_row_pair_packer dut (
    .clk        (clk),
    .reset      (reset),
    .row_valid  (row_valid),
    .row_ready  (row_ready),
    .row_in     (row_in),
    .pool_start (pool_start),
    .pool_in    (pool_in),
    .pool_end   (pool_end),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0] sb[$];
  logic [RW-1:0] even_m;
  bit  par = 1'b0;
  bit  auto_en = 1'b0;
  int  starts = 0, fds = 0, cyc = 0, ends_sent = 0, last_end_cyc = -100, fd_cyc = -1;

  typedef struct {
    bit          v;
    logic [14:0] pix;
    bit          pe;
    bit          er;
    bit          es;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] mkrow(input int base, input int step);
    logic [RW-1:0] r;
    r = '0;
    for (int c = 0; c < CONV_COLS; c++)
      r[RW-1-c*CONV_PIX_W -: CONV_PIX_W] = CONV_PIX_W'(base + step * c);
    return r;
  endfunction

  task automatic model_accept(input logic [RW-1:0] r);
    if (!par) even_m = r;
    else      sb.push_back({even_m, r});
    par = !par;
  endtask

  task automatic model_clear();
    sb.delete();
    par = 1'b0;
  endtask

  task automatic send_row(input logic [RW-1:0] r);
    bit done;
    done = 1'b0;
    row_valid = 1'b1;
    row_in    = r;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (row_ready) begin
        model_accept(r);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    row_valid = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL send_row: row never accepted, got ready=0 expected ready=1");
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // pool_in scoreboard and event counters
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      if (pool_start) begin
        starts++;
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL pool_in: got unexpected pool_start expected none");
        end else begin
          chk("pool_in", pool_in, sb.pop_front());
        end
      end
      if (frame_done) begin
        fds++;
        fd_cyc = cyc;
      end
    end
  end

  // pooling stage model: end_flag 5 cycles after each pool_start
  initial forever begin
    @(negedge clk);
    if (auto_en && pool_start && !reset) begin
      repeat (5) @(posedge clk);
      #1 auto_end = 1'b1;
      ends_sent++;
      last_end_cyc = cyc;
      @(posedge clk);
      #1 auto_end = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    bit bad;
    bit seen;

    //         v  pix       pe er es
    tbl[0]  = '{1, 15'h0001, 0, 1, 0};
    tbl[1]  = '{1, 15'h0002, 1, 1, 0};  // pool_end while idle: ignored
    tbl[2]  = '{0, 15'h0000, 0, 0, 0};
    tbl[3]  = '{1, 15'h0003, 0, 1, 1};
    tbl[4]  = '{1, 15'h0004, 0, 1, 0};
    tbl[5]  = '{1, 15'h07AA, 0, 0, 0};  // dropped: not ready
    tbl[6]  = '{1, 15'h0155, 0, 0, 0};  // dropped: not ready
    tbl[7]  = '{0, 15'h0000, 1, 0, 0};
    tbl[8]  = '{0, 15'h0000, 0, 0, 0};
    tbl[9]  = '{0, 15'h0000, 0, 1, 1};
    tbl[10] = '{0, 15'h0000, 0, 1, 0};

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_row_ready", PW'(row_ready), PW'(0));
    chk("rst_pool_start", PW'(pool_start), PW'(0));
    chk("rst_pool_in", pool_in, '0);
    chk("rst_frame_done", PW'(frame_done), PW'(0));
    @(posedge clk); #1 reset = 1'b0;

    // handshake table: first pair, overlap while busy, stall, pool_end reissue
    for (int i = 0; i < 11; i++) begin
      row_valid = tbl[i].v;
      row_in    = tbl[i].v ? mkrow(int'(tbl[i].pix), 0) : '0;
      man_end   = tbl[i].pe;
      @(negedge clk);
      chk($sformatf("tbl%0d_row_ready", i), PW'(row_ready), PW'(tbl[i].er));
      chk($sformatf("tbl%0d_pool_start", i), PW'(pool_start), PW'(tbl[i].es));
      if (tbl[i].v && tbl[i].er) model_accept(row_in);
      @(posedge clk); #1;
    end
    row_valid = 1'b0;
    man_end   = 1'b0;
    chk("tbl_frame_done", PW'(fds), PW'(0));
    chk("tbl_starts", PW'(starts), PW'(2));

    // mid-frame reset discards a partial pair
    reset = 1'b1;
    model_clear();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst2_pool_in", pool_in, '0);
    chk("rst2_row_ready", PW'(row_ready), PW'(0));
    @(posedge clk); #1 reset = 1'b0;
    send_row(mkrow(500, 1));
    reset = 1'b1;
    model_clear();
    @(negedge clk);
    chk("rst3_pool_start", PW'(pool_start), PW'(0));
    chk("rst3_frame_done", PW'(frame_done), PW'(0));
    @(posedge clk); #1 reset = 1'b0;
    s0 = starts;
    send_row(mkrow(1000, 2));
    send_row(mkrow(2000, 5));
    repeat (4) @(posedge clk); #1;
    chk("rst_pair_starts", PW'(starts - s0), PW'(1));

    // full frame with pooling responder; idle pool_ends first must not count
    reset = 1'b1;
    model_clear();
    @(posedge clk); #1 reset = 1'b0;
    s0 = starts;
    fds = 0;
    ends_sent = 0;
    man_end = 1'b1;
    repeat (3) @(posedge clk); #1 man_end = 1'b0;
    auto_en = 1'b1;
    for (int r = 0; r < CONV_ROWS; r++) send_row(mkrow(r * 64, 3));
    bad  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
      else if (row_ready) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("frame_done_seen", PW'(seen), PW'(1));
    chk("frame_ready_gap", PW'(bad), PW'(0));
    chk("frame_starts", PW'(starts - s0), PW'(12));
    chk("frame_ends", PW'(ends_sent), PW'(12));
    chk("frame_done_latency", PW'(fd_cyc), PW'(last_end_cyc + 1));
    @(negedge clk);
    chk("frame_done_pulse", PW'(frame_done), PW'(0));
    chk("frame_ready_back", PW'(row_ready), PW'(1));
    @(posedge clk); #1 man_end = 1'b1;
    @(posedge clk); #1 man_end = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk("frame_done_count", PW'(fds), PW'(1));
    chk("frame_starts_final", PW'(starts - s0), PW'(12));
    chk("sb_empty", PW'(sb.size()), PW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
